load_unit: RTL

Multicycle load sequencer for the CPU datapath. It accepts a load request (address plus load type) from the control unit and issues one aligned word read to memory. It waits a fixed memory latency, then extracts the addressed byte, halfword or word and sign- or zero-extends it. It is the direct upstream producer of the memory-read data that the MemReadCtrl 6:1 selector forwards to the register file, and it also raises a misalignment flag for the exception logic.

---
 rtl/load_unit_pkg.sv | 30 +++
 rtl/load_unit_if.sv | 24 ++
 rtl/load_unit_extract.sv | 37 +++
 rtl/load_unit.sv | 85 ++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared encodings for the load sequencer: load types, FSM states and the
// alignment rule that decides whether a request reaches memory at all.
package load_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LH  = 3'b001,
        LT_LHU = 3'b010,
        LT_LB  = 3'b011,
        LT_LBU = 3'b100
    } load_type_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    // Encodings 101-111 fall into the default arm and behave as LW.
    function automatic logic is_aligned(input logic [2:0] lt, input logic [1:0] a);
        case (lt)
            LT_LH, LT_LHU: return ~a[0];
            LT_LB, LT_LBU: return 1'b1;
            default:       return (a == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request/response and memory-read bus of the load sequencer. The slave
// modport is the load unit; the master side is control plus memory.
interface load_unit_if;
    logic        start;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        misaligned;

    modport slave (
        input  start, load_type, addr, mem_data_in,
        output mem_addr, mem_rd, busy, done, result, misaligned
    );

    modport master (
        output start, load_type, addr, mem_data_in,
        input  mem_addr, mem_rd, busy, done, result, misaligned
    );
endinterface

// File: rtl/load_unit_extract.sv
// Byte/halfword lane select with sign or zero extension from a little-endian
// word. Purely combinational so sub-word store logic can share it.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_load_type,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_value = i_word;
        case (i_load_type)
            LT_LH:   o_value = {{16{w_half[15]}}, w_half};
            LT_LHU:  o_value = {16'h0000, w_half};
            LT_LB:   o_value = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  o_value = {24'h000000, w_byte};
            default: o_value = i_word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Multicycle load sequencer: one aligned word read per accepted request,
// fixed memory latency, then sub-word extraction into a held result.
module load_unit
    import load_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic      i_clk,
    input  logic      i_reset,
    load_unit_if.slave bus
);

    localparam int            CW       = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    state_e        r_state;
    state_e        w_next;
    logic [1:0]    r_addr_lo;
    logic [2:0]    r_load_type;
    logic [31:0]   r_mem_addr;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_data;
    logic [31:0]   r_result;
    logic [31:0]   w_ext;
    logic          w_aligned;
    logic          w_accept;

    assign w_aligned = is_aligned(bus.load_type, bus.addr[1:0]);
    assign w_accept  = (r_state == S_IDLE) && bus.start && w_aligned;

    load_extract u_extract (
        .i_word      (r_data),
        .i_addr      (r_addr_lo),
        .i_load_type (r_load_type),
        .o_value     (w_ext)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = w_aligned ? S_ISSUE : S_ERR;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Reset also clears the data register so an aborted read cannot leak out.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_addr_lo   <= 2'b00;
            r_load_type <= 3'b000;
            r_mem_addr  <= 32'h0;
            r_cnt       <= '0;
            r_data      <= 32'h0;
            r_result    <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr_lo   <= bus.addr[1:0];
                r_load_type <= bus.load_type;
                r_mem_addr  <= {bus.addr[31:2], 2'b00};
            end
            if (r_state == S_ISSUE) r_cnt <= CNT_INIT;
            if (r_state == S_WAIT) begin
                if (r_cnt == '0) r_data <= bus.mem_data_in;
                else             r_cnt  <= r_cnt - 1'b1;
            end
            if (r_state == S_DONE) r_result <= w_ext;
        end
    end

    // The extracted value is shown directly during DONE so result is valid
    // alongside the done pulse; afterwards the registered copy holds it.
    assign bus.result     = (r_state == S_DONE) ? w_ext : r_result;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_rd     = (r_state == S_ISSUE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.misaligned = (r_state == S_ERR);

endmodule
